obuf_pingpong_acc: RTL

// Next-generation output buffer: two ARRAY_M-lane halves (ping/pong). The systolic array writes or

---
 rtl/obuf_pingpong_acc.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/obuf_pingpong_acc.sv
// Ping-pong output buffer: the compute side writes or accumulates into one half while the mem side
// drains or preloads the other; the halves swap once both sides have signalled done.
module obuf_pingpong_acc #(
    parameter int ARRAY_M        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 8,
    parameter int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
    parameter int BUF_ID_W       = $clog2(ARRAY_M / GROUP_SIZE),
    parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          buf_write_req,
    input  logic                          buf_write_acc,
    input  logic [BUF_ADDR_WIDTH-1:0]     buf_write_addr,
    input  logic [ARRAY_M*DATA_WIDTH-1:0] buf_write_data,
    input  logic                          buf_read_req,
    input  logic [BUF_ADDR_WIDTH-1:0]     buf_read_addr,
    output logic [ARRAY_M*DATA_WIDTH-1:0] buf_read_data,
    input  logic                          buf_done,
    output logic                          buf_ready,
    input  logic                          mem_write_req,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_write_addr,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_write_data,
    input  logic                          mem_read_req,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_read_addr,
    output logic [MEM_DATA_WIDTH-1:0]     mem_read_data,
    input  logic                          mem_done,
    output logic                          mem_ready,
    output logic                          active_half,
    output logic                          swap_pulse,
    output logic                          wr_drop_err
);
    localparam int DW        = DATA_WIDTH;
    localparam int DEPTH     = 1 << BUF_ADDR_WIDTH;
    localparam int NUM_WORDS = ARRAY_M / GROUP_SIZE;
    localparam int ID_W      = (BUF_ID_W > 0) ? BUF_ID_W : 1;

    logic active_half_reg, comp_flag_reg, mem_flag_reg, swap_pulse_reg, wr_drop_err_reg;
    logic both_done, wr_accept;

    assign both_done   = comp_flag_reg & mem_flag_reg;
    assign wr_accept   = buf_write_req & ~comp_flag_reg;
    assign buf_ready   = ~comp_flag_reg;
    assign mem_ready   = ~mem_flag_reg;
    assign active_half = active_half_reg;
    assign swap_pulse  = swap_pulse_reg;
    assign wr_drop_err = wr_drop_err_reg;

    // mem_flag starts set so the very first buf_done swaps without waiting on the mem side.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_half_reg <= 1'b0;
            comp_flag_reg   <= 1'b0;
            mem_flag_reg    <= 1'b1;
            swap_pulse_reg  <= 1'b0;
            wr_drop_err_reg <= 1'b0;
        end else begin
            swap_pulse_reg <= both_done;
            if (both_done) begin
                active_half_reg <= ~active_half_reg;
                comp_flag_reg   <= 1'b0;
                mem_flag_reg    <= 1'b0;
            end else begin
                comp_flag_reg <= comp_flag_reg | buf_done;
                mem_flag_reg  <= mem_flag_reg | mem_done;
            end
            if (buf_write_req && comp_flag_reg)
                wr_drop_err_reg <= 1'b1;
        end
    end

    // Write pipeline stage 1 (stage 2 is the RAM commit on the following edge).
    logic                          s1_valid_reg, s1_acc_reg, s1_half_reg;
    logic [BUF_ADDR_WIDTH-1:0]     s1_addr_reg;
    logic [ARRAY_M*DATA_WIDTH-1:0] s1_data_reg;
    logic                          fwd_hit;

    assign fwd_hit = s1_valid_reg && (s1_half_reg == active_half_reg) && (s1_addr_reg == buf_write_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_acc_reg   <= 1'b0;
            s1_half_reg  <= 1'b0;
            s1_addr_reg  <= '0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= wr_accept;
            if (wr_accept) begin
                s1_acc_reg  <= buf_write_acc;
                s1_half_reg <= active_half_reg;
                s1_addr_reg <= buf_write_addr;
                s1_data_reg <= buf_write_data;
            end
        end
    end

    logic [ID_W-1:0]           mem_wr_id, mem_rd_id, mem_rd_id_reg;
    logic [BUF_ADDR_WIDTH-1:0] mem_wr_row, mem_rd_row;

    generate
        if (BUF_ID_W > 0) begin : g_word_id
            assign mem_wr_id  = mem_write_addr[BUF_ID_W-1:0];
            assign mem_wr_row = mem_write_addr[MEM_ADDR_WIDTH-1:BUF_ID_W];
            assign mem_rd_id  = mem_read_addr[BUF_ID_W-1:0];
            assign mem_rd_row = mem_read_addr[MEM_ADDR_WIDTH-1:BUF_ID_W];
        end else begin : g_no_word_id
            assign mem_wr_id  = '0;
            assign mem_wr_row = mem_write_addr;
            assign mem_rd_id  = '0;
            assign mem_rd_row = mem_read_addr;
        end
    endgenerate

    logic [ARRAY_M*DATA_WIDTH-1:0] mem_rd_lanes;

    // One RAM per lane, addressed by {half, row}.
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_M; gi++) begin : g_lane
            logic [DW-1:0] ram [0:2*DEPTH-1];
            logic [DW-1:0] old_reg, s1_result, buf_rd_reg, mem_rd_reg;
            logic [DW-1:0] s1_lane;

            assign s1_lane   = s1_data_reg[gi*DW +: DW];
            assign s1_result = s1_acc_reg ? (old_reg + s1_lane) : s1_lane;

            // Stage-2 write comes last so it wins over a mem write to the same location.
            always_ff @(posedge clk) begin
                if (wr_accept)
                    old_reg <= fwd_hit ? s1_result : ram[{active_half_reg, buf_write_addr}];
                if (mem_write_req && (mem_wr_id == ID_W'(gi / GROUP_SIZE)))
                    ram[{~active_half_reg, mem_wr_row}] <= mem_write_data[(gi % GROUP_SIZE)*DW +: DW];
                if (s1_valid_reg && !reset)
                    ram[{s1_half_reg, s1_addr_reg}] <= s1_result;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    buf_rd_reg <= '0;
                    mem_rd_reg <= '0;
                end else begin
                    if (buf_read_req)
                        buf_rd_reg <= ram[{active_half_reg, buf_read_addr}];
                    if (mem_read_req)
                        mem_rd_reg <= ram[{~active_half_reg, mem_rd_row}];
                end
            end

            assign buf_read_data[gi*DW +: DW] = buf_rd_reg;
            assign mem_rd_lanes[gi*DW +: DW]  = mem_rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            mem_rd_id_reg <= '0;
        else if (mem_read_req)
            mem_rd_id_reg <= mem_rd_id;
    end

    always_comb begin
        mem_read_data = '0;
        for (int w = 0; w < NUM_WORDS; w++)
            if (mem_rd_id_reg == ID_W'(w))
                mem_read_data = mem_rd_lanes[w*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end

endmodule
